// File: rtl/sine_osc_multi.sv
// Coupled-form (Minsky) sine/cosine test-tone oscillator with a prescaled
// sample strobe, start/stop control, rising zero-crossing and period measurement.
module sine_osc_multi #(
  parameter int unsigned        W         = 20,
  parameter int unsigned        SHIFT_W   = 4,
  parameter int unsigned        DIV_W     = 16,
  parameter int unsigned        PER_W     = 16,
  parameter logic [W-1:0]       DEF_AMP   = W'(20'h02666),
  parameter logic [SHIFT_W-1:0] DEF_SHIFT = SHIFT_W'(8)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [W-1:0]       cfg_amp,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic               start,
  input  logic               stop,
  output logic [W-1:0]       sine,
  output logic [W-1:0]       cosine,
  output logic               sample_valid,
  output logic               zero_cross,
  output logic [PER_W-1:0]   period,
  output logic               period_valid,
  output logic               running
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]         state_q, state_d;

  logic [W-1:0]       amp_sh_q, amp_sh_d;
  logic [SHIFT_W-1:0] shift_sh_q, shift_sh_d;
  logic [DIV_W-1:0]   div_sh_q, div_sh_d;

  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   presc_q, presc_d;

  logic signed [W-1:0] sine_q, sine_d;
  logic signed [W-1:0] cos_q, cos_d;
  logic signed [W-1:0] s_next, c_next;

  logic [PER_W-1:0]   cnt_q, cnt_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic               first_q, first_d;

  logic               sv_q, sv_d;
  logic               zc_q, zc_d;
  logic               pv_q, pv_d;

  logic               tick;
  logic               rise;

  // Cosine update uses the freshly computed sine to keep the orbit closed.
  assign s_next = sine_q + (cos_q >>> shift_q);
  assign c_next = cos_q - (s_next >>> shift_q);

  assign tick = (presc_q == div_q);
  assign rise = sine_q[W-1] & ~s_next[W-1];

  always_comb begin
    state_d    = state_q;
    amp_sh_d   = amp_sh_q;
    shift_sh_d = shift_sh_q;
    div_sh_d   = div_sh_q;
    shift_d    = shift_q;
    div_d      = div_q;
    presc_d    = presc_q;
    sine_d     = sine_q;
    cos_d      = cos_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    first_d    = first_q;
    sv_d       = 1'b0;
    zc_d       = 1'b0;
    pv_d       = 1'b0;

    if (cfg_load) begin
      amp_sh_d   = cfg_amp;
      shift_sh_d = cfg_shift;
      div_sh_d   = cfg_div;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d = S_PRIME;
        end
      end

      S_PRIME: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
          sine_d  = '0;
          cos_d   = $signed(amp_sh_q);
          presc_d = '0;
          cnt_d   = '0;
          first_d = 1'b1;
          div_d   = div_sh_q;
          shift_d = (shift_sh_q == '0) ?
                    SHIFT_W'(1) : shift_sh_q;
        end
      end

      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          presc_d = '0;
        end else if (start) begin
          state_d = S_PRIME;
        end else if (tick) begin
          presc_d = '0;
          sine_d  = s_next;
          cos_d   = c_next;
          sv_d    = 1'b1;
          if (rise) begin
            zc_d  = 1'b1;
            cnt_d = '0;
            if (first_q) begin
              first_d = 1'b0;
            end else begin
              pv_d  = 1'b1;
              per_d = (cnt_q == '1) ?
                      cnt_q : cnt_q + PER_W'(1);
            end
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + PER_W'(1);
          end
        end else begin
          presc_d = presc_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      amp_sh_q   <= DEF_AMP;
      shift_sh_q <= DEF_SHIFT;
      div_sh_q   <= '0;
      shift_q    <= DEF_SHIFT;
      div_q      <= '0;
      presc_q    <= '0;
      sine_q     <= '0;
      cos_q      <= '0;
      cnt_q      <= '0;
      per_q      <= '0;
      first_q    <= 1'b1;
      sv_q       <= 1'b0;
      zc_q       <= 1'b0;
      pv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      amp_sh_q   <= amp_sh_d;
      shift_sh_q <= shift_sh_d;
      div_sh_q   <= div_sh_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      presc_q    <= presc_d;
      sine_q     <= sine_d;
      cos_q      <= cos_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      first_q    <= first_d;
      sv_q       <= sv_d;
      zc_q       <= zc_d;
      pv_q       <= pv_d;
    end
  end

  assign sine         = sine_q;
  assign cosine       = cos_q;
  assign sample_valid = sv_q;
  assign zero_cross   = zc_q;
  assign period       = per_q;
  assign period_valid = pv_q;
  assign running      = (state_q == S_RUN);

endmodule

// File: tb/tb_sine_osc_multi.sv
// Bench for sine_osc_multi: a cycle table for start-up/control sequences,
// then hand-written long runs for period, prescaler, stop and reset.
module tb_sine_osc_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_load;
  logic [19:0] cfg_amp;
  logic [3:0]  cfg_shift;
  logic [15:0] cfg_div;
  logic        start;
  logic        stop;
  logic [19:0] sine;
  logic [19:0] cosine;
  logic        sample_valid;
  logic        zero_cross;
  logic [15:0] period;
  logic        period_valid;
  logic        running;

  int checks   = 0;
  int failures = 0;

  sine_osc_multi dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_load     (cfg_load),
    .cfg_amp      (cfg_amp),
    .cfg_shift    (cfg_shift),
    .cfg_div      (cfg_div),
    .start        (start),
    .stop         (stop),
    .sine         (sine),
    .cosine       (cosine),
    .sample_valid (sample_valid),
    .zero_cross   (zero_cross),
    .period       (period),
    .period_valid (period_valid),
    .running      (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        ld;
    logic [19:0] amp;
    logic [3:0]  sh;
    logic [15:0] dv;
    logic        st;
    logic        sp;
    logic [19:0] e_sin;
    logic [19:0] e_cos;
    logic        e_sv;
    logic        e_run;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(
    string n, logic ld, logic [19:0] a,
    logic [3:0] sh, logic [15:0] dv,
    logic st, logic sp, logic [19:0] es,
    logic [19:0] ec, logic ev, logic er);
    vec_t v;
    v.nm = n; v.ld = ld; v.amp = a;
    v.sh = sh; v.dv = dv; v.st = st;
    v.sp = sp; v.e_sin = es; v.e_cos = ec;
    v.e_sv = ev; v.e_run = er;
    return v;
  endfunction

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h",
               n, act, exp);
    end
  endtask

  task automatic chk_rng(string n, int act,
                         int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d..%0d",
               n, act, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cfg_load = 0; cfg_amp = '0; cfg_shift = '0;
    cfg_div = '0; start = 0; stop = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, last, ncross, npv, nomiss, peak, c;
    int gap, gapbad, seen100, seen101, bad;
    logic [19:0] xs, xc, xb;
    logic loaded;

    vecs[0]  = mk("idle",   0, 0, 0, 0, 0, 0, 20'h0, 20'h0, 0, 0);
    vecs[1]  = mk("start",  0, 0, 0, 0, 1, 0, 20'h0, 20'h0, 0, 0);
    vecs[2]  = mk("prime",  0, 0, 0, 0, 0, 0, 20'h0, 20'h02666, 0, 1);
    vecs[3]  = mk("s1",     0, 0, 0, 0, 0, 0, 20'h26, 20'h02666, 1, 1);
    vecs[4]  = mk("s2",     0, 0, 0, 0, 0, 0, 20'h4c, 20'h02666, 1, 1);
    vecs[5]  = mk("s3",     0, 0, 0, 0, 0, 0, 20'h72, 20'h02666, 1, 1);
    vecs[6]  = mk("stop",   0, 0, 0, 0, 0, 1, 20'h72, 20'h02666, 0, 0);
    vecs[7]  = mk("hold",   0, 0, 0, 0, 0, 0, 20'h72, 20'h02666, 0, 0);
    vecs[8]  = mk("ldst",   1, 20'h10000, 4, 3, 1, 0,
                  20'h72, 20'h02666, 0, 0);
    vecs[9]  = mk("prime2", 0, 0, 0, 0, 0, 0, 20'h0, 20'h10000, 0, 1);
    vecs[10] = mk("div_w1", 0, 0, 0, 0, 0, 0, 20'h0, 20'h10000, 0, 1);
    vecs[11] = mk("div_w2", 0, 0, 0, 0, 0, 0, 20'h0, 20'h10000, 0, 1);
    vecs[12] = mk("div_w3", 0, 0, 0, 0, 0, 0, 20'h0, 20'h10000, 0, 1);
    vecs[13] = mk("div_t1", 0, 0, 0, 0, 0, 0, 20'h1000, 20'hff00, 1, 1);
    vecs[14] = mk("div_h1", 0, 0, 0, 0, 0, 0, 20'h1000, 20'hff00, 0, 1);
    vecs[15] = mk("stst",   0, 0, 0, 0, 1, 1, 20'h1000, 20'hff00, 0, 0);
    vecs[16] = mk("ld_sh0", 1, 20'h100, 0, 0, 1, 0,
                  20'h1000, 20'hff00, 0, 0);
    vecs[17] = mk("prime3", 0, 0, 0, 0, 0, 0, 20'h0, 20'h100, 0, 1);
    vecs[18] = mk("sh0_s1", 0, 0, 0, 0, 0, 0, 20'h80, 20'hc0, 1, 1);
    vecs[19] = mk("sh0_s2", 0, 0, 0, 0, 0, 0, 20'he0, 20'h50, 1, 1);
    vecs[20] = mk("restart",0, 0, 0, 0, 1, 0, 20'he0, 20'h50, 0, 0);
    vecs[21] = mk("prime4", 0, 0, 0, 0, 0, 0, 20'h0, 20'h100, 0, 1);
    vecs[22] = mk("re_s1",  0, 0, 0, 0, 0, 0, 20'h80, 20'hc0, 1, 1);

    idle_in();
    reset = 1;
    repeat (3) step();
    chk("rst_sine", 32'(sine), 0);
    chk("rst_cos", 32'(cosine), 0);
    chk("rst_sv", 32'(sample_valid), 0);
    chk("rst_zc", 32'(zero_cross), 0);
    chk("rst_per", 32'(period), 0);
    chk("rst_pv", 32'(period_valid), 0);
    chk("rst_run", 32'(running), 0);
    reset = 0;

    for (int i = 0; i < 23; i++) begin
      cfg_load = vecs[i].ld; cfg_amp = vecs[i].amp;
      cfg_shift = vecs[i].sh; cfg_div = vecs[i].dv;
      start = vecs[i].st; stop = vecs[i].sp;
      step();
      chk({vecs[i].nm, "_sin"}, 32'(sine), 32'(vecs[i].e_sin));
      chk({vecs[i].nm, "_cos"}, 32'(cosine), 32'(vecs[i].e_cos));
      chk({vecs[i].nm, "_sv"}, 32'(sample_valid), 32'(vecs[i].e_sv));
      chk({vecs[i].nm, "_run"}, 32'(running), 32'(vecs[i].e_run));
    end
    idle_in();

    // Reset in the middle of a run: outputs clear, shadows revert.
    reset = 1;
    step();
    reset = 0;
    chk("mr_sine", 32'(sine), 0);
    chk("mr_cos", 32'(cosine), 0);
    chk("mr_sv", 32'(sample_valid), 0);
    chk("mr_per", 32'(period), 0);
    chk("mr_run", 32'(running), 0);
    start = 1;
    step();
    start = 0;
    step();
    chk("mr_prime_cos", 32'(cosine), 32'h02666);
    step();
    chk("mr_s1_sv", 32'(sample_valid), 1);
    chk("mr_s1_sin", 32'(sine), 32'h26);

    // Default tone, 5000 samples at one per clock.
    idx = 1; last = 0; ncross = 0; npv = 0;
    nomiss = 0; peak = 0;
    for (int i = 1; i < 5000; i++) begin
      step();
      if (!sample_valid) nomiss++;
      else begin
        idx++;
        c = int'($signed(cosine));
        if (c < 0) c = -c;
        if (c > peak) peak = c;
        if (zero_cross) begin
          ncross++;
          if (ncross == 1)
            chk("def_first_pv", 32'(period_valid), 0);
          else begin
            chk_rng("def_interval", idx - last, 1606, 1610);
            chk("def_pv", 32'(period_valid), 1);
            chk_rng("def_period", int'(period), 1606, 1610);
            npv++;
          end
          last = idx;
        end
      end
    end
    chk("def_every_clk", 32'(nomiss), 0);
    chk("def_ncross", 32'(ncross), 3);
    chk("def_npv", 32'(npv), 2);
    chk_rng("def_peak", peak, 9732, 9928);

    // amp 0x10000, shift 4, div 3; reload mid-run must not take effect.
    stop = 1;
    step();
    stop = 0;
    cfg_load = 1; cfg_amp = 20'h10000;
    cfg_shift = 4; cfg_div = 3;
    step();
    idle_in();
    start = 1;
    step();
    start = 0;
    npv = 0; gap = -1; gapbad = 0;
    seen100 = 0; seen101 = 0; loaded = 0;
    for (int i = 0; i < 12000 && npv < 6; i++) begin
      step();
      cfg_load = 0;
      if (gap >= 0) gap++;
      if (sample_valid) begin
        if (gap >= 0 && gap != 4) gapbad++;
        gap = 0;
      end
      if (period_valid) begin
        npv++;
        chk_rng("c_period", int'(period), 100, 101);
        if (period == 16'd100) seen100++;
        if (period == 16'd101) seen101++;
        if (!loaded) begin
          cfg_load = 1; cfg_amp = 20'h04000;
          cfg_shift = 8; cfg_div = 0;
          loaded = 1;
        end
      end
    end
    idle_in();
    chk("c_npv", 32'(npv), 6);
    chk("c_gap4", 32'(gapbad), 0);
    chk("c_seen100", 32'(seen100 > 0), 1);
    chk("c_seen101", 32'(seen101 > 0), 1);

    // Stop mid-run and hold.
    repeat (7) step();
    xb = sine;
    stop = 1;
    step();
    stop = 0;
    xs = sine; xc = cosine;
    chk("stop_keep", 32'(xs), 32'(xb));
    chk("stop_run", 32'(running), 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sine !== xs || cosine !== xc || sample_valid ||
          zero_cross || period_valid || running)
        bad++;
    end
    chk("stop_hold100", 32'(bad), 0);

    // Restart picks up the shadow loaded during the previous run.
    start = 1;
    step();
    start = 0;
    step();
    chk("rs_sin0", 32'(sine), 0);
    chk("rs_cosamp", 32'(cosine), 32'h04000);
    chk("rs_run", 32'(running), 1);
    step();
    chk("rs_s1_sv", 32'(sample_valid), 1);
    chk("rs_s1_sin", 32'(sine), 32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
